// File: rtl/bids22_pkg.sv
// bids22_pkg: shared opcodes, sequencer state/error codes and config helpers for the bids22 host sequencer.
package bids22_pkg;

    typedef enum logic [3:0] {
        NoOp       = 4'd0,
        Unlock     = 4'd1,
        Lock       = 4'd2,
        LoadX      = 4'd3,
        LoadY      = 4'd4,
        LoadZ      = 4'd5,
        SetXYZmask = 4'd6,
        SetTimer   = 4'd7,
        BidCharge  = 4'd8
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_ROUND,
        S_CLOSE,
        S_UNLOCK,
        S_DONE
    } seq_state_t;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [2:0]  mask;
        logic [31:0] timer;
        logic [31:0] cost;
        logic [31:0] key;
    } cfg_t;

    localparam logic [1:0] SEQ_OK      = 2'b00;
    localparam logic [1:0] SEQ_CFG_ERR = 2'b01;
    localparam logic [1:0] SEQ_TIMEOUT = 2'b10;
    localparam logic [2:0] LAST_STEP   = 3'd6;

    // Steps 0..5 map onto LoadX..BidCharge in opcode order; the final step is Lock.
    function automatic opcode_t cfg_op(input logic [2:0] step);
        return (step == LAST_STEP) ? Lock : opcode_t'(4'(step) + 4'd3);
    endfunction

    function automatic logic [31:0] cfg_data(input cfg_t c, input logic [2:0] step);
        return (step == 3'd0) ? c.x :
               (step == 3'd1) ? c.y :
               (step == 3'd2) ? c.z :
               (step == 3'd3) ? {29'b0, c.mask} :
               (step == 3'd4) ? c.timer :
               (step == 3'd5) ? c.cost : c.key;
    endfunction

endpackage

// File: rtl/bids22_dn_cnt.sv
// bids22_dn_cnt: loadable down-counter that saturates at zero and flags when it is there.
module bids22_dn_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bids22_host_seq.sv
// bids22_host_seq: host-side command sequencer that runs one full bids22 auction round
// (config, Lock, bid window, close, result capture, Unlock) per start pulse.
module bids22_host_seq
    import bids22_pkg::*;
#(
    parameter int RESULT_TIMEOUT = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:0]      cfg_x_value,
    input  logic [31:0]      cfg_y_value,
    input  logic [31:0]      cfg_z_value,
    input  logic [2:0]       cfg_mask,
    input  logic [31:0]      cfg_timer,
    input  logic [31:0]      cfg_cost,
    input  logic [31:0]      cfg_key,
    input  logic [CNT_W-1:0] round_cycles,
    input  logic             ready,
    input  logic             roundOver,
    input  logic [2:0]       err,
    input  logic [31:0]      maxBid,
    input  logic             X_win,
    input  logic             Y_win,
    input  logic             Z_win,
    output opcode_t          C_op,
    output logic [31:0]      C_data,
    output logic             C_start,
    output logic             busy,
    output logic             done,
    output logic [1:0]       seq_err,
    output logic [31:0]      result_max,
    output logic [2:0]       result_win,
    output logic [2:0]       result_err
);

    // The close window covers the C_start falling cycle plus RESULT_TIMEOUT+1 further cycles.
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(RESULT_TIMEOUT + 1);

    seq_state_t       state_q, state_d;
    logic [2:0]       step_q, step_d, step_nx;
    cfg_t             cfg_q, cfg_d;
    logic [CNT_W-1:0] rc_q, rc_d, rnd_val;
    opcode_t          op_q, op_d;
    logic [31:0]      data_q, data_d, rmax_q, rmax_d;
    logic             cstart_q, cstart_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]       serr_q, serr_d;
    logic [2:0]       rwin_q, rwin_d, rerr_q, rerr_d;
    logic             rnd_load, rnd_en, rnd_zero, to_load, to_en, to_zero;

    assign step_nx = step_q + 3'd1;
    assign rnd_val = (rc_q == '0) ? '0 : rc_q - 1'b1;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cfg_d    = cfg_q;
        rc_d     = rc_q;
        op_d     = op_q;
        data_d   = data_q;
        cstart_d = cstart_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        serr_d   = serr_q;
        rmax_d   = rmax_q;
        rwin_d   = rwin_q;
        rerr_d   = rerr_q;
        rnd_load = 1'b0;
        rnd_en   = 1'b0;
        to_load  = 1'b0;
        to_en    = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                cfg_d   = {cfg_x_value, cfg_y_value, cfg_z_value, cfg_mask, cfg_timer, cfg_cost, cfg_key};
                rc_d    = round_cycles;
                busy_d  = 1'b1;
                step_d  = 3'd0;
                op_d    = LoadX;
                data_d  = cfg_x_value;
                serr_d  = SEQ_OK;
                rmax_d  = '0;
                rwin_d  = '0;
                rerr_d  = '0;
                state_d = S_CFG;
            end
            S_CFG: if (err != 3'd0) begin
                op_d    = NoOp;
                data_d  = '0;
                rerr_d  = err;
                serr_d  = SEQ_CFG_ERR;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end else if (ready && step_q == LAST_STEP) begin
                op_d     = NoOp;
                data_d   = '0;
                cstart_d = 1'b1;
                rnd_load = 1'b1;
                state_d  = S_ROUND;
            end else if (ready) begin
                step_d = step_nx;
                op_d   = cfg_op(step_nx);
                data_d = cfg_data(cfg_q, step_nx);
            end
            S_ROUND: if (rnd_zero) begin
                cstart_d = 1'b0;
                to_load  = 1'b1;
                state_d  = S_CLOSE;
            end else begin
                rnd_en = 1'b1;
            end
            S_CLOSE: begin
                to_en = 1'b1;
                // A result arriving on the expiry cycle still wins over the timeout.
                if (roundOver || to_zero) begin
                    op_d    = Unlock;
                    data_d  = cfg_q.key;
                    state_d = S_UNLOCK;
                    serr_d  = roundOver ? serr_q : SEQ_TIMEOUT;
                    rmax_d  = roundOver ? maxBid : rmax_q;
                    rwin_d  = roundOver ? {Z_win, Y_win, X_win} : rwin_q;
                    rerr_d  = roundOver ? err : rerr_q;
                end
            end
            S_UNLOCK: begin
                op_d    = NoOp;
                data_d  = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            cfg_q    <= '0;
            rc_q     <= '0;
            op_q     <= NoOp;
            data_q   <= '0;
            cstart_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            serr_q   <= SEQ_OK;
            rmax_q   <= '0;
            rwin_q   <= '0;
            rerr_q   <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cfg_q    <= cfg_d;
            rc_q     <= rc_d;
            op_q     <= op_d;
            data_q   <= data_d;
            cstart_q <= cstart_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            serr_q   <= serr_d;
            rmax_q   <= rmax_d;
            rwin_q   <= rwin_d;
            rerr_q   <= rerr_d;
        end
    end

    bids22_dn_cnt #(.CNT_W(CNT_W)) u_round_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .load_i (rnd_load),
        .val_i  (rnd_val),
        .en_i   (rnd_en),
        .zero_o (rnd_zero)
    );

    bids22_dn_cnt #(.CNT_W(CNT_W)) u_timeout_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .load_i (to_load),
        .val_i  (TO_LOAD),
        .en_i   (to_en),
        .zero_o (to_zero)
    );

    assign C_op       = op_q;
    assign C_data     = data_q;
    assign C_start    = cstart_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign seq_err    = serr_q;
    assign result_max = rmax_q;
    assign result_win = rwin_q;
    assign result_err = rerr_q;

endmodule

// File: tb/tb_bids22_host_seq.sv
// tb_bids22_host_seq: directed self-checking bench for the bids22 host sequencer.
module tb_bids22_host_seq;
    import bids22_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, start, ready, roundOver, X_win, Y_win, Z_win;
    logic [31:0] cfg_x_value, cfg_y_value, cfg_z_value, cfg_timer, cfg_cost, cfg_key, maxBid;
    logic [2:0]  cfg_mask, err;
    logic [15:0] round_cycles;
    opcode_t     C_op;
    logic [31:0] C_data, result_max;
    logic        C_start, busy, done;
    logic [1:0]  seq_err;
    logic [2:0]  result_win, result_err;

    int          checks = 0;
    int          failures = 0;
    int          cyc, unlocks;
    logic [31:0] exp_data [7];
    int          exp_op [7] = '{3, 4, 5, 6, 7, 8, 2};

    bids22_host_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .cfg_x_value(cfg_x_value), .cfg_y_value(cfg_y_value), .cfg_z_value(cfg_z_value),
        .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_cost(cfg_cost), .cfg_key(cfg_key),
        .round_cycles(round_cycles), .ready(ready), .roundOver(roundOver), .err(err),
        .maxBid(maxBid), .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win),
        .C_op(C_op), .C_data(C_data), .C_start(C_start), .busy(busy), .done(done),
        .seq_err(seq_err), .result_max(result_max), .result_win(result_win), .result_err(result_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] x, y, z, input logic [2:0] m,
                           input logic [31:0] t, c, k, input logic [15:0] r);
        cfg_x_value = x; cfg_y_value = y; cfg_z_value = z; cfg_mask = m;
        cfg_timer = t; cfg_cost = c; cfg_key = k; round_cycles = r;
        exp_data = '{x, y, z, {29'b0, m}, t, c, k};
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Walks the seven config ops; stall_len cycles of ready=0 are inserted at stall_step.
    task automatic check_cfg_ops(input int stall_step, input int stall_len);
        for (int s = 0; s < 7; s++) begin
            for (int j = 0; j <= ((s == stall_step) ? stall_len : 0); j++) begin
                ready = (s == stall_step && j < stall_len) ? 1'b0 : 1'b1;
                chk($sformatf("op%0d_%0d", s, j), 32'(C_op), 32'(exp_op[s]));
                chk($sformatf("data%0d_%0d", s, j), C_data, exp_data[s]);
                chk($sformatf("cstart_cfg%0d", s), 32'(C_start), 32'd0);
                tick;
            end
        end
        ready = 1'b1;
    endtask

    task automatic check_round(input int r);
        int n;
        n = (r < 1) ? 1 : r;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("cstart_hi%0d", i), 32'(C_start), 32'd1);
            chk($sformatf("round_noop%0d", i), 32'(C_op), 32'd0);
            tick;
        end
        chk("cstart_fall", 32'(C_start), 32'd0);
    endtask

    // Starts on the first C_start-low cycle; cycle index of done returned in c.
    task automatic finish_seq(input int ro_delay, input logic [31:0] key, output int c, output int u);
        c = 0;
        u = 0;
        while (!done && c < 300) begin
            roundOver = (c == ro_delay);
            if (C_op == Unlock) begin
                u++;
                chk("unlock_data", C_data, key);
            end
            tick;
            c++;
        end
        roundOver = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; ready = 1'b1; roundOver = 1'b0; err = 3'd0;
        maxBid = '0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick;
        chk("rst_op", 32'(C_op), 32'd0);
        chk("rst_cstart", 32'(C_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_serr", 32'(seq_err), 32'd0);
        reset_n = 1'b1;
        tick;

        // nominal round
        set_cfg(100, 200, 300, 3'd7, 32'h20, 1, 32'h0F0F0F0F, 4);
        maxBid = 50; Y_win = 1'b1;
        pulse_start;
        chk("nom_busy", 32'(busy), 32'd1);
        check_cfg_ops(-1, 0);
        check_round(4);
        finish_seq(2, 32'h0F0F0F0F, cyc, unlocks);
        chk("nom_lat", 32'(cyc), 32'd4);
        chk("nom_unlocks", 32'(unlocks), 32'd1);
        chk("nom_max", result_max, 32'd50);
        chk("nom_win", 32'(result_win), 32'b010);
        chk("nom_serr", 32'(seq_err), 32'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd0);
        chk("start_in_done", 32'(busy), 32'd0);
        tick;
        chk("idle_after_done", 32'(busy), 32'd0);

        // ready stall on SetTimer, captured err passes through
        set_cfg(11, 22, 33, 3'b101, 5, 2, 32'hA5A5A5A5, 2);
        maxBid = 77; X_win = 1'b1; Y_win = 1'b0; Z_win = 1'b1;
        pulse_start;
        check_cfg_ops(4, 3);
        check_round(2);
        err = 3'b011;
        finish_seq(1, 32'hA5A5A5A5, cyc, unlocks);
        err = 3'd0;
        chk("stall_lat", 32'(cyc), 32'd3);
        chk("stall_max", result_max, 32'd77);
        chk("stall_win", 32'(result_win), 32'b101);
        chk("stall_rerr", 32'(result_err), 32'd3);
        chk("stall_serr", 32'(seq_err), 32'd0);
        tick;

        // config error during LoadZ
        set_cfg(1, 2, 3, 3'd1, 4, 5, 32'h12345678, 3);
        pulse_start;
        tick;
        tick;
        chk("cerr_loadz", 32'(C_op), 32'd5);
        err = 3'b100;
        tick;
        err = 3'd0;
        chk("cerr_noop", 32'(C_op), 32'd0);
        chk("cerr_done", 32'(done), 32'd1);
        chk("cerr_busy", 32'(busy), 32'd0);
        chk("cerr_serr", 32'(seq_err), 32'd1);
        chk("cerr_rerr", 32'(result_err), 32'd4);
        chk("cerr_max_cleared", result_max, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("cerr_quiet%0d", i), 32'(C_op), 32'd0);
            chk($sformatf("cerr_nostart%0d", i), 32'(C_start), 32'd0);
        end

        // roundOver never arrives
        set_cfg(7, 7, 7, 3'd3, 9, 1, 32'h55AA55AA, 3);
        pulse_start;
        check_cfg_ops(-1, 0);
        check_round(3);
        finish_seq(-1, 32'h55AA55AA, cyc, unlocks);
        chk("to_lat", 32'(cyc), 32'd67);
        chk("to_unlocks", 32'(unlocks), 32'd1);
        chk("to_serr", 32'(seq_err), 32'd2);
        chk("to_max", result_max, 32'd0);
        tick;

        // round_cycles=0, cfg changes and start held while busy
        set_cfg(9, 8, 7, 3'd2, 6, 3, 32'hCAFEF00D, 0);
        pulse_start;
        cfg_x_value = '1; cfg_y_value = '1; cfg_z_value = '1; cfg_mask = 3'd5;
        cfg_timer = '1; cfg_cost = '1; cfg_key = 32'h0BADBEEF; round_cycles = 5;
        start = 1'b1;
        check_cfg_ops(-1, 0);
        start = 1'b0;
        check_round(0);
        finish_seq(0, 32'hCAFEF00D, cyc, unlocks);
        chk("r0_lat", 32'(cyc), 32'd2);
        chk("r0_unlocks", 32'(unlocks), 32'd1);
        tick;

        // async reset mid-ROUND, then a fresh nominal run
        set_cfg(100, 200, 300, 3'd7, 32'h20, 1, 32'h0F0F0F0F, 4);
        maxBid = 50; X_win = 1'b0; Y_win = 1'b1; Z_win = 1'b0;
        pulse_start;
        check_cfg_ops(-1, 0);
        tick;
        chk("pre_rst_cstart", 32'(C_start), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_cstart", 32'(C_start), 32'd0);
        chk("arst_op", 32'(C_op), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        #3 reset_n = 1'b1;
        tick;
        pulse_start;
        check_cfg_ops(-1, 0);
        check_round(4);
        finish_seq(2, 32'h0F0F0F0F, cyc, unlocks);
        chk("post_rst_lat", 32'(cyc), 32'd4);
        chk("post_rst_max", result_max, 32'd50);
        chk("post_rst_win", 32'(result_win), 32'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
